imm_gen_stage: RTL and testbench

//  Registered, handshaked immediate-generation stage between fetch and execute. Accepts

---
 rtl/imm_gen_stage_pkg.sv | 27 ++
 rtl/imm_gen_stage_if.sv | 28 ++
 rtl/imm_gen_stage_decode_comb.sv | 62 ++++++
 rtl/imm_gen_stage.sv | 82 ++++++++
 tb/tb_imm_gen_stage.sv | 373 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imm_gen_stage_pkg.sv
// Shared opcode and format encodings for the immediate-generation stage,
// its decoder and any instruction builders.
package imm_gen_stage_pkg;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_R  = 3'd0,
    FMT_I  = 3'd1,
    FMT_S  = 3'd2,
    FMT_B  = 3'd3,
    FMT_U  = 3'd4,
    FMT_J  = 3'd5,
    FMT_SH = 3'd6
  } fmt_t;
endpackage

// File: rtl/imm_gen_stage_if.sv
// Fetch-side and execute-side handshake bundle of the immediate-generation stage.
interface imm_gen_stage_if
  import imm_gen_stage_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int PC_WIDTH = 32
) ();
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         in_instr;
  logic [PC_WIDTH-1:0] in_pc;
  logic                out_valid;
  logic                out_ready;
  logic [XLEN-1:0]     out_imm;
  fmt_t                out_fmt;
  logic                out_illegal;
  logic [31:0]         out_instr;
  logic [PC_WIDTH-1:0] out_pc;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_instr, out_pc
  );
  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_instr, out_pc
  );
endinterface

// File: rtl/imm_gen_stage_decode_comb.sv
// Combinational RISC-V immediate decoder: instruction -> sign-extended
// immediate, format code and illegal-opcode flag.
module imm_decode_comb
  import imm_gen_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output fmt_t            fmt,
  output logic            illegal
);
  localparam bit RV64 = (XLEN == 64);

  logic [6:0] op;
  logic       is_shift;
  assign op       = instr[6:0];
  assign is_shift = (instr[13:12] == 2'b01);  // funct3 001 / 101

  always_comb begin
    imm     = '0;
    fmt     = FMT_R;
    illegal = 1'b0;
    case (op)
      OPC_OP: ;
      OPC_OP32: illegal = !RV64;
      OPC_OP_IMM, OPC_OP_IMM32: begin
        if (op == OPC_OP_IMM32 && !RV64) begin
          illegal = 1'b1;
        end else if (is_shift) begin
          // Word shifts only ever take a 5-bit shamt, even on RV64
          fmt = FMT_SH;
          imm = (RV64 && op == OPC_OP_IMM) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
        end else begin
          fmt = FMT_I;
          imm = XLEN'($signed(instr[31:20]));
        end
      end
      OPC_LOAD, OPC_JALR, OPC_MISC_MEM, OPC_SYSTEM: begin
        fmt = FMT_I;
        imm = XLEN'($signed(instr[31:20]));
      end
      OPC_STORE: begin
        fmt = FMT_S;
        imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      end
      OPC_BRANCH: begin
        fmt = FMT_B;
        imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt = FMT_U;
        imm = XLEN'($signed({instr[31:12], 12'b0}));
      end
      OPC_JAL: begin
        fmt = FMT_J;
        imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      end
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage with a 2-entry skid buffer:
// entry0 drives the outputs, entry1 absorbs one instruction of back-pressure.
module imm_gen_stage
  import imm_gen_stage_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int PC_WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  imm_gen_stage_if.slave bus
);
  typedef struct packed {
    logic [XLEN-1:0]     imm;
    fmt_t                fmt;
    logic                illegal;
    logic [31:0]         instr;
    logic [PC_WIDTH-1:0] pc;
  } entry_t;

  entry_t          e0, e1, din;
  logic            v0, v1, rdy;
  logic            acc, con, v1_n;
  logic [XLEN-1:0] dimm;
  fmt_t            dfmt;
  logic            dill;

  imm_decode_comb #(.XLEN(XLEN)) u_dec (
    .instr   (bus.in_instr),
    .imm     (dimm),
    .fmt     (dfmt),
    .illegal (dill)
  );

  assign din  = '{imm: dimm, fmt: dfmt, illegal: dill, instr: bus.in_instr, pc: bus.in_pc};
  assign acc  = bus.in_valid & rdy;
  assign con  = v0 & bus.out_ready;
  // Skid slot fills only when the head is occupied and stays put
  assign v1_n = con ? (v1 & acc) : (v1 | (acc & v0));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v0  <= 1'b0;
      v1  <= 1'b0;
      rdy <= 1'b0;
      e0  <= '0;
      e1  <= '0;
    end else if (flush) begin
      v0  <= 1'b0;
      v1  <= 1'b0;
      rdy <= 1'b1;
    end else begin
      v1  <= v1_n;
      rdy <= !v1_n;
      if (con) begin
        if (v1) begin
          e0 <= e1;
          if (acc) e1 <= din;
        end else begin
          v0 <= acc;
          if (acc) e0 <= din;
        end
      end else if (acc) begin
        if (!v0) begin
          v0 <= 1'b1;
          e0 <= din;
        end else begin
          e1 <= din;
        end
      end
    end
  end

  assign bus.in_ready    = rdy;
  assign bus.out_valid   = v0;
  assign bus.out_imm     = e0.imm;
  assign bus.out_fmt     = e0.fmt;
  assign bus.out_illegal = e0.illegal;
  assign bus.out_instr   = e0.instr;
  assign bus.out_pc      = e0.pc;
endmodule

// File: tb/tb_imm_gen_stage.sv
// Self-checking bench for imm_gen_stage: directed scenarios plus random traffic
// against a queue-based FIFO model and an arithmetic immediate reference.
module tb_imm_gen_stage;
  import imm_gen_stage_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   errs = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  imm_gen_stage_if #(.XLEN(32), .PC_WIDTH(32)) bus32 ();
  imm_gen_stage_if #(.XLEN(64), .PC_WIDTH(32)) bus64 ();

  imm_gen_stage #(.XLEN(32), .PC_WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus32.slave));
  imm_gen_stage #(.XLEN(64), .PC_WIDTH(32)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus64.slave));

  // ---------------- reference: FIFO occupancy model for the 32-bit instance
  logic [63:0] mq[$];   // {pc, instr} in acceptance order
  logic        m_rdy = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_rdy <= 1'b0;
    end else if (flush) begin
      mq.delete();
      m_rdy <= 1'b1;
    end else begin
      if (mq.size() > 0 && bus32.out_ready) void'(mq.pop_front());
      if (bus32.in_valid && m_rdy) mq.push_back({bus32.in_pc, bus32.in_instr});
      m_rdy <= (mq.size() < 2);
    end
  end

  // ---------------- reference: immediate decoding from the ISA field layout
  task automatic ref_dec(input logic [31:0] ins, input int xlen,
                         output logic [63:0] imm, output logic [2:0] fmt, output logic ill);
    longint s;
    logic [6:0] op;
    logic [2:0] f3;
    s = $signed(ins);
    op = ins[6:0];
    f3 = ins[14:12];
    imm = '0; fmt = 3'd0; ill = 1'b0;
    case (op)
      OPC_OP: ;
      OPC_OP32: ill = (xlen == 32);
      OPC_OP_IMM, OPC_OP_IMM32: begin
        if (op == OPC_OP_IMM32 && xlen == 32) ill = 1'b1;
        else if (f3 == 3'd1 || f3 == 3'd5) begin
          fmt = 3'd6;
          imm = (xlen == 64 && op == OPC_OP_IMM) ? 64'(ins[25:20]) : 64'(ins[24:20]);
        end else begin
          fmt = 3'd1; imm = s >>> 20;
        end
      end
      OPC_LOAD, OPC_JALR, OPC_MISC_MEM, OPC_SYSTEM: begin fmt = 3'd1; imm = s >>> 20; end
      OPC_STORE:  begin fmt = 3'd2; imm = ((s >>> 25) << 5) | 64'(ins[11:7]); end
      OPC_BRANCH: begin
        fmt = 3'd3;
        imm = ((s >>> 31) << 12) | (64'(ins[7]) << 11) | (64'(ins[30:25]) << 5) | (64'(ins[11:8]) << 1);
      end
      OPC_LUI, OPC_AUIPC: begin fmt = 3'd4; imm = s & ~64'hFFF; end
      OPC_JAL: begin
        fmt = 3'd5;
        imm = ((s >>> 31) << 20) | (64'(ins[19:12]) << 12) | (64'(ins[20]) << 11) | (64'(ins[30:21]) << 1);
      end
      default: ill = 1'b1;
    endcase
    if (xlen == 32) imm[63:32] = '0;
  endtask

  // ---------------- instruction builders
  function automatic logic [31:0] mk_i(logic [6:0] op, logic [2:0] f3, logic [11:0] i);
    return {i, 5'd2, f3, 5'd3, op};
  endfunction
  function automatic logic [31:0] mk_s(logic [11:0] i);
    return {i[11:5], 5'd2, 5'd1, 3'b010, i[4:0], OPC_STORE};
  endfunction
  function automatic logic [31:0] mk_b(logic [12:0] i);
    return {i[12], i[10:5], 5'd2, 5'd1, 3'b101, i[4:1], i[11], OPC_BRANCH};
  endfunction
  function automatic logic [31:0] mk_u(logic [19:0] u);
    return {u, 5'd5, OPC_LUI};
  endfunction
  function automatic logic [31:0] mk_j(logic [20:0] i);
    return {i[20], i[10:1], i[11], i[19:12], 5'd1, OPC_JAL};
  endfunction

  task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] pc, input bit ordy);
    bus32.in_valid  = v;
    bus32.in_instr  = ins;
    bus32.in_pc     = pc;
    bus32.out_ready = ordy;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- scenarios
  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 32'hFFC40193, 32'h40, 1'b1);
    repeat (3) cyc();
    checks++;
    if ({bus32.out_valid, bus32.in_ready, bus32.out_imm, bus32.out_fmt, bus32.out_illegal,
         bus32.out_instr, bus32.out_pc} !== '0) begin
      errs++;
      $display("FAIL reset32 got vld=%b rdy=%b imm=%h fmt=%0d ill=%b instr=%h pc=%h exp all zero",
               bus32.out_valid, bus32.in_ready, bus32.out_imm, bus32.out_fmt, bus32.out_illegal,
               bus32.out_instr, bus32.out_pc);
    end
    checks++;
    if ({bus64.out_valid, bus64.in_ready, bus64.out_imm} !== '0) begin
      errs++;
      $display("FAIL reset64 got vld=%b rdy=%b imm=%h exp 0 0 0", bus64.out_valid, bus64.in_ready, bus64.out_imm);
    end
    drive(1'b0, '0, '0, 1'b1);
    rst_n = 1'b1;
    cyc();
    checks++;
    if ({bus32.in_ready, bus32.out_valid} !== 2'b10) begin
      errs++;
      $display("FAIL reset_release got rdy=%b vld=%b exp rdy=1 vld=0", bus32.in_ready, bus32.out_valid);
    end
  endtask

  task automatic test_addi();
    drive(1'b1, 32'hFFC40193, 32'h100, 1'b1);
    cyc();
    drive(1'b0, '0, '0, 1'b1);
    checks++;
    if ({bus32.out_valid, bus32.out_imm, bus32.out_fmt, bus32.out_illegal, bus32.out_pc}
        !== {1'b1, 32'hFFFFFFFC, 3'd1, 1'b0, 32'h100}) begin
      errs++;
      $display("FAIL addi got vld=%b imm=%h fmt=%0d ill=%b pc=%h exp 1 fffffffc 1 0 00000100",
               bus32.out_valid, bus32.out_imm, bus32.out_fmt, bus32.out_illegal, bus32.out_pc);
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins [4];
    logic [31:0] eimm [4];
    logic [2:0]  efmt [4];
    ins[0] = mk_b(13'd12);  eimm[0] = 32'hC;    efmt[0] = 3'd3;
    ins[1] = mk_j(21'd80);  eimm[1] = 32'h50;   efmt[1] = 3'd5;
    ins[2] = mk_u(20'h2);   eimm[2] = 32'h2000; efmt[2] = 3'd4;
    ins[3] = mk_s(12'd12);  eimm[3] = 32'hC;    efmt[3] = 3'd2;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, ins[i], 32'h200 + 32'(4 * i), 1'b1);
      cyc();
      checks++;
      if ({bus32.out_valid, bus32.out_instr, bus32.out_imm, bus32.out_fmt, bus32.in_ready}
          !== {1'b1, ins[i], eimm[i], efmt[i], 1'b1}) begin
        errs++;
        $display("FAIL b2b[%0d] got vld=%b instr=%h imm=%h fmt=%0d rdy=%b exp 1 %h %h %0d 1", i,
                 bus32.out_valid, bus32.out_instr, bus32.out_imm, bus32.out_fmt, bus32.in_ready,
                 ins[i], eimm[i], efmt[i]);
      end
    end
    drive(1'b0, '0, '0, 1'b1);
    cyc();
  endtask

  task automatic test_shift32();
    logic [31:0] ins [4];
    logic [36:0] exp [4];   // {imm, fmt, illegal, pad}
    ins[0] = mk_i(OPC_OP_IMM, 3'b001, 12'd31);   exp[0] = {32'h1F, 3'd6, 1'b0, 1'b0};
    ins[1] = mk_i(OPC_OP_IMM, 3'b101, 12'h43F);  exp[1] = {32'h1F, 3'd6, 1'b0, 1'b0};
    ins[2] = mk_i(OPC_OP_IMM32, 3'b000, 12'd5);  exp[2] = {32'h0,  3'd0, 1'b1, 1'b0};
    ins[3] = 32'hFFFFFFFF;                       exp[3] = {32'h0,  3'd0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, ins[i], 32'h300, 1'b1);
      cyc();
      checks++;
      if ({bus32.out_imm, bus32.out_fmt, bus32.out_illegal, 1'b0} !== exp[i] || bus32.out_valid !== 1'b1) begin
        errs++;
        $display("FAIL dec32[%0d] got vld=%b imm=%h fmt=%0d ill=%b exp imm=%h fmt=%0d ill=%b", i,
                 bus32.out_valid, bus32.out_imm, bus32.out_fmt, bus32.out_illegal,
                 exp[i][36:5], exp[i][4:2], exp[i][1]);
      end
    end
    drive(1'b0, '0, '0, 1'b1);
    cyc();
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b, c;
    a = mk_i(OPC_OP_IMM, 3'b000, 12'h7FF);
    b = mk_s(12'h800);
    c = mk_u(20'hFFFFF);
    drive(1'b1, a, 32'hA0, 1'b0);
    cyc();
    drive(1'b1, b, 32'hB0, 1'b0);
    cyc();
    drive(1'b1, c, 32'hC0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({bus32.in_ready, bus32.out_valid, bus32.out_instr, bus32.out_imm, bus32.out_pc}
          !== {1'b0, 1'b1, a, 32'h7FF, 32'hA0}) begin
        errs++;
        $display("FAIL stall[%0d] got rdy=%b vld=%b instr=%h imm=%h pc=%h exp 0 1 %h 000007ff 000000a0",
                 k, bus32.in_ready, bus32.out_valid, bus32.out_instr, bus32.out_imm, bus32.out_pc, a);
      end
      if (k < 2) cyc();
    end
    drive(1'b1, c, 32'hC0, 1'b1);
    cyc();
    checks++;
    if ({bus32.out_valid, bus32.out_instr, bus32.out_imm, bus32.in_ready} !== {1'b1, b, 32'hFFFFF800, 1'b1}) begin
      errs++;
      $display("FAIL release_b got vld=%b instr=%h imm=%h rdy=%b exp 1 %h fffff800 1",
               bus32.out_valid, bus32.out_instr, bus32.out_imm, bus32.in_ready, b);
    end
    cyc();
    drive(1'b0, '0, '0, 1'b1);
    checks++;
    if ({bus32.out_valid, bus32.out_instr, bus32.out_imm, bus32.out_pc} !== {1'b1, c, 32'hFFFFF000, 32'hC0}) begin
      errs++;
      $display("FAIL release_c got vld=%b instr=%h imm=%h pc=%h exp 1 %h fffff000 000000c0",
               bus32.out_valid, bus32.out_instr, bus32.out_imm, bus32.out_pc, c);
    end
    cyc();
    checks++;
    if (bus32.out_valid !== 1'b0) begin
      errs++;
      $display("FAIL drain got vld=%b exp 0", bus32.out_valid);
    end
  endtask

  task automatic test_flush();
    drive(1'b1, mk_u(20'h1), 32'h10, 1'b0);
    cyc();
    drive(1'b1, mk_u(20'h2), 32'h14, 1'b0);
    cyc();
    checks++;
    if ({bus32.in_ready, bus32.out_valid} !== 2'b01) begin
      errs++;
      $display("FAIL flush_pre got rdy=%b vld=%b exp rdy=0 vld=1", bus32.in_ready, bus32.out_valid);
    end
    flush = 1'b1;
    drive(1'b1, mk_u(20'h3), 32'h18, 1'b1);
    cyc();
    flush = 1'b0;
    checks++;
    if ({bus32.in_ready, bus32.out_valid} !== 2'b10) begin
      errs++;
      $display("FAIL flush got rdy=%b vld=%b exp rdy=1 vld=0", bus32.in_ready, bus32.out_valid);
    end
    drive(1'b0, '0, '0, 1'b1);
    cyc();
    checks++;
    if (bus32.out_valid !== 1'b0) begin
      errs++;
      $display("FAIL flush_taken got vld=%b exp 0", bus32.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, mk_j(21'h1FFFFE), 32'h20, 1'b0);
    cyc();
    drive(1'b1, mk_b(13'h1FFE), 32'h24, 1'b0);
    cyc();
    rst_n = 1'b0;
    cyc();
    checks++;
    if ({bus32.out_valid, bus32.in_ready, bus32.out_imm, bus32.out_instr} !== '0) begin
      errs++;
      $display("FAIL reset_mid got vld=%b rdy=%b imm=%h instr=%h exp all zero",
               bus32.out_valid, bus32.in_ready, bus32.out_imm, bus32.out_instr);
    end
    drive(1'b0, '0, '0, 1'b1);
    rst_n = 1'b1;
    cyc();
    cyc();
    checks++;
    if ({bus32.in_ready, bus32.out_valid} !== 2'b10) begin
      errs++;
      $display("FAIL reset_mid_after got rdy=%b vld=%b exp rdy=1 vld=0", bus32.in_ready, bus32.out_valid);
    end
  endtask

  task automatic test_xlen64();
    logic [31:0] ins [6];
    logic [67:0] exp [6];   // {imm, fmt, illegal}
    ins[0] = mk_i(OPC_OP_IMM, 3'b101, 12'h43F);   exp[0] = {64'h3F, 3'd6, 1'b0};
    ins[1] = mk_u(20'h80000);                     exp[1] = {64'hFFFFFFFF80000000, 3'd4, 1'b0};
    ins[2] = mk_i(OPC_OP_IMM32, 3'b000, 12'd5);   exp[2] = {64'h5, 3'd1, 1'b0};
    ins[3] = mk_i(OPC_OP_IMM32, 3'b001, 12'h03F); exp[3] = {64'h1F, 3'd6, 1'b0};
    ins[4] = {25'h0, OPC_OP32};                   exp[4] = {64'h0, 3'd0, 1'b0};
    ins[5] = mk_j(21'h100000);                    exp[5] = {64'hFFFFFFFFFFF00000, 3'd5, 1'b0};
    for (int i = 0; i < 6; i++) begin
      bus64.in_valid = 1'b1;
      bus64.in_instr = ins[i];
      bus64.in_pc    = 32'(i);
      cyc();
      checks++;
      if ({bus64.out_imm, bus64.out_fmt, bus64.out_illegal} !== exp[i] || bus64.out_valid !== 1'b1) begin
        errs++;
        $display("FAIL dec64[%0d] got vld=%b imm=%h fmt=%0d ill=%b exp imm=%h fmt=%0d ill=%b", i,
                 bus64.out_valid, bus64.out_imm, bus64.out_fmt, bus64.out_illegal,
                 exp[i][67:4], exp[i][3:1], exp[i][0]);
      end
    end
    bus64.in_valid = 1'b0;
    cyc();
  endtask

  task automatic test_random();
    logic [6:0]  ops [16];
    logic [63:0] eimm;
    logic [2:0]  efmt;
    logic        eill;
    logic [31:0] r;
    ops = '{OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_AUIPC, OPC_OP_IMM32, OPC_STORE, OPC_OP, OPC_LUI,
            OPC_OP32, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM, OPC_OP_IMM, 7'h7F, 7'h0B};
    for (int n = 0; n < 500; n++) begin
      checks++;
      if (bus32.in_ready !== m_rdy || bus32.out_valid !== (mq.size() != 0)) begin
        errs++;
        $display("FAIL rnd_hs cyc=%0d got rdy=%b vld=%b exp rdy=%b vld=%b",
                 n, bus32.in_ready, bus32.out_valid, m_rdy, mq.size() != 0);
      end
      if (mq.size() != 0) begin
        ref_dec(mq[0][31:0], 32, eimm, efmt, eill);
        checks++;
        if ({bus32.out_instr, bus32.out_pc, bus32.out_imm, bus32.out_fmt, bus32.out_illegal}
            !== {mq[0][31:0], mq[0][63:32], eimm[31:0], efmt, eill}) begin
          errs++;
          $display("FAIL rnd_data cyc=%0d got instr=%h pc=%h imm=%h fmt=%0d ill=%b exp %h %h %h %0d %b",
                   n, bus32.out_instr, bus32.out_pc, bus32.out_imm, bus32.out_fmt, bus32.out_illegal,
                   mq[0][31:0], mq[0][63:32], eimm[31:0], efmt, eill);
        end
      end
      r = $urandom();
      drive($urandom_range(0, 99) < 65, {r[31:7], ops[$urandom_range(0, 15)]}, $urandom(),
            $urandom_range(0, 99) < 60);
      flush = ($urandom_range(0, 99) < 4);
      cyc();
    end
    flush = 1'b0;
    drive(1'b0, '0, '0, 1'b1);
    cyc();
  endtask

  initial begin
    drive(1'b0, '0, '0, 1'b1);
    bus64.in_valid  = 1'b0;
    bus64.in_instr  = '0;
    bus64.in_pc     = '0;
    bus64.out_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_addi();
    test_back_to_back();
    test_shift32();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_xlen64();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
